fetch_unit: RTL and testbench

//  Parametrised instruction fetch unit at the head of the core pipeline.
//  - Holds PC; issues in-order word fetches to imem over a valid/ready request channel.
//  - Buffers returned instructions with their PC in a fetch queue; presents them to decode over valid/ready.
//  - Supports halt and branch redirect: redirect flushes the queue and discards in-flight responses.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 54 +++++
 rtl/fetch_unit.sv | 143 ++++++++++++++
 tb/tb_fetch_unit.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-unit constants: default widths, PC step, FSM encoding, queue entry width.
package fetch_pkg;

  localparam int XLEN_DEF = 32;
  localparam int ILEN_DEF = 32;
  localparam int PC_INC   = 4;

  typedef enum logic {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } fetch_state_e;

  // A queue entry carries the instruction's PC above the instruction word.
  function automatic int fq_entry_w(input int xlen, input int ilen);
    return xlen + ilen;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush, DEPTH (power of 2) x W; pointers carry an extra wrap bit.
// Latency: a push is visible at the head on the next cycle.
// Backpressure: push is ignored when full unless a pop happens in the same cycle; flush wins over push/pop.
module fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           push_dat,
  input  logic                   pop,
  input  logic                   flush,
  output logic [W-1:0]           head_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count    = wr_ptr - rd_ptr;
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign head_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset: only slots between the pointers are ever read as valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, in-order imem requests, fetch queue to decode; FETCH_MISALIGN_CHK_EN adds a sticky misaligned-redirect fault.
// Latency: imem response -> instr_valid 1 cycle; redirect -> redirect_taken 1 cycle.
// Backpressure: instr_ready stalls the queue; requests issue only while queued + in-flight < FQ_DEPTH and in-flight < MAX_OUTST.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEF,
  parameter int              ILEN         = ILEN_DEF,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              FQ_DEPTH     = 4,
  parameter int              MAX_OUTST    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            halt,
  input  logic            redirect_en,
  input  logic [XLEN-1:0] redirect_addr,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [ILEN-1:0] instr_data,
  output logic [XLEN-1:0] instr_pc,
  output logic            redirect_taken,
  output logic            misalign_fault
);

  localparam int              CW        = $clog2(FQ_DEPTH) + 1;
  localparam int              EW        = fq_entry_w(XLEN, ILEN);
  localparam logic [CW:0]     DEPTH_LIM = (CW+1)'(FQ_DEPTH);
  localparam logic [CW-1:0]   OUTST_LIM = CW'(MAX_OUTST);
  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(PC_INC);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic            redir_taken_q;
  logic            fault_q;

  logic [XLEN-1:0] redir_pc;
  logic            req_acc;
  logic            fq_push, fq_pop, fq_flush;
  logic [EW-1:0]   fq_head;
  logic            fq_empty;
  logic            fq_full_unused;
  logic [CW-1:0]   fq_count;

  assign redir_pc = {redirect_addr[XLEN-1:2], 2'b00};

`ifdef FETCH_MISALIGN_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                             fault_q <= 1'b0;
    else if (redirect_en && (redirect_addr[1:0] != 2'b00)) fault_q <= 1'b1;
  end
`else
  logic unused_addr_lo;
  assign unused_addr_lo = ^redirect_addr[1:0];
  assign fault_q        = 1'b0;
`endif

  // A redirect cancels any same-cycle request, so imem never sees an accept the unit won't count.
  assign imem_req_valid = rst_n && !redirect_en && !fault_q && !halt && (state_q == FETCH) &&
                          (outst_q < OUTST_LIM) && (({1'b0, fq_count} + {1'b0, outst_q}) < DEPTH_LIM);
  assign imem_req_addr  = pc_q;
  assign req_acc        = imem_req_valid && imem_req_ready;
  assign outst_d        = outst_q + CW'(req_acc) - CW'(imem_rsp_valid);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    drop_d   = drop_q;
    fq_push  = 1'b0;
    fq_flush = 1'b0;
    if (req_acc) pc_d = pc_q + PC_STEP;
    if (redirect_en) begin
      // Every response still in flight after this cycle belongs to the squashed stream.
      pc_d     = redir_pc;
      rsp_pc_d = redir_pc;
      fq_flush = 1'b1;
      drop_d   = outst_d;
      state_d  = (outst_d != '0) ? FLUSH : FETCH;
    end else begin
      if (imem_rsp_valid) begin
        if (drop_q != '0) begin
          drop_d = drop_q - CW'(1);
        end else begin
          fq_push  = 1'b1;
          rsp_pc_d = rsp_pc_q + PC_STEP;
        end
      end
      if ((state_q == FLUSH) && (drop_d == '0)) state_d = FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FETCH;
      pc_q          <= RESET_VECTOR;
      rsp_pc_q      <= RESET_VECTOR;
      outst_q       <= '0;
      drop_q        <= '0;
      redir_taken_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outst_q       <= outst_d;
      drop_q        <= drop_d;
      redir_taken_q <= redirect_en;
    end
  end

  assign fq_pop = instr_valid && instr_ready;

  fetch_fifo #(
    .W     (EW),
    .DEPTH (FQ_DEPTH)
  ) u_fq (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fq_push),
    .push_dat ({rsp_pc_q, imem_rsp_data}),
    .pop      (fq_pop),
    .flush    (fq_flush),
    .head_dat (fq_head),
    .full     (fq_full_unused),
    .empty    (fq_empty),
    .count    (fq_count)
  );

  assign instr_valid    = !fq_empty;
  assign instr_data     = instr_valid ? fq_head[ILEN-1:0] : '0;
  assign instr_pc       = instr_valid ? fq_head[ILEN +: XLEN] : '0;
  assign redirect_taken = redir_taken_q;
  assign misalign_fault = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random traffic against an in-order memory and a PC-stream reference model.
module tb_fetch_unit;

  localparam int          XLEN      = 32;
  localparam int          ILEN      = 32;
  localparam int          FQ_DEPTH  = 4;
  localparam int          MAX_OUTST = 2;
  localparam logic [31:0] RV        = 32'h0;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            halt;
  logic            redirect_en;
  logic [XLEN-1:0] redirect_addr;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;
  logic            instr_valid;
  logic            instr_ready;
  logic [ILEN-1:0] instr_data;
  logic [XLEN-1:0] instr_pc;
  logic            redirect_taken;
  logic            misalign_fault;

  always #5 clk = ~clk;

  fetch_unit #(
    .XLEN         (XLEN),
    .ILEN         (ILEN),
    .RESET_VECTOR (RV),
    .FQ_DEPTH     (FQ_DEPTH),
    .MAX_OUTST    (MAX_OUTST)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .halt           (halt),
    .redirect_en    (redirect_en),
    .redirect_addr  (redirect_addr),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .redirect_taken (redirect_taken),
    .misalign_fault (misalign_fault)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          ep;
  } mreq_t;

  mreq_t       mq[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          epoch = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          ep_acc = 0;
  int          ep_pop = 0;
  int          pops = 0;
  int          accs = 0;
  logic [31:0] exp_req_pc;
  logic [31:0] exp_dec_pc;
  logic [31:0] last_pop_pc;
  logic [31:0] last_acc_addr;
  logic        prev_redir;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic int old_pending();
    int n = 0;
    foreach (mq[i]) if (mq[i].ep != epoch) n++;
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic drive_mem();
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  endtask

  // One clock cycle: observe at negedge, update the model, advance past the posedge.
  task automatic step();
    logic  acc;
    logic  pop;
    mreq_t m;
    @(negedge clk);
    if (halt) check("halt_no_req", 32'(imem_req_valid), 32'd0);
    if (old_pending() > 0) check("flush_no_req", 32'(imem_req_valid), 32'd0);
    check("redirect_taken", 32'(redirect_taken), 32'(prev_redir));
    acc = imem_req_valid && imem_req_ready;
    pop = instr_valid && instr_ready && !redirect_en;
    if (acc) begin
      check("req_addr", imem_req_addr, exp_req_pc);
      check("outst_limit", 32'(mq.size() < MAX_OUTST), 32'd1);
      check("credit", 32'((ep_acc - ep_pop) < FQ_DEPTH), 32'd1);
      m.addr = imem_req_addr;
      m.due  = cyc + int'($urandom_range(lat_max, lat_min));
      m.ep   = epoch;
      mq.push_back(m);
      last_acc_addr = imem_req_addr;
      exp_req_pc    = exp_req_pc + 32'd4;
      ep_acc++;
      accs++;
    end
    if (imem_rsp_valid) mq.delete(0);
    if (pop) begin
      check("dec_pc", instr_pc, exp_dec_pc);
      check("dec_data", instr_data, mem_word(exp_dec_pc));
      last_pop_pc = instr_pc;
      exp_dec_pc  = exp_dec_pc + 32'd4;
      ep_pop++;
      pops++;
    end
    if (redirect_en) begin
      epoch++;
      exp_req_pc = redirect_addr & ~32'h3;
      exp_dec_pc = redirect_addr & ~32'h3;
      ep_acc     = 0;
      ep_pop     = 0;
    end
    prev_redir = redirect_en;
    @(posedge clk);
    #1;
    cyc++;
    drive_mem();
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    halt           = 1'b0;
    redirect_en    = 1'b0;
    redirect_addr  = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    instr_ready    = 1'b0;
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_req_addr", imem_req_addr, RV);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr_data", instr_data, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);
    check("rst_redirect_taken", 32'(redirect_taken), 32'd0);
    check("rst_misalign", 32'(misalign_fault), 32'd0);
    mq.delete();
    epoch++;
    exp_req_pc = RV;
    exp_dec_pc = RV;
    ep_acc     = 0;
    ep_pop     = 0;
    prev_redir = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc++;
    drive_mem();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int          n0;
    int          nf;
    logic [31:0] tgt;

    do_reset();

    // Streaming with a 1-cycle memory: one instruction per cycle after two cycles of fill.
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    lat_min = 1; lat_max = 1;
    n0 = pops;
    repeat (12) step();
    check("stream_pops", 32'(pops - n0), 32'd10);

    // Decode stalled: queue fills to depth and requests stop.
    instr_ready = 1'b0;
    n0 = pops;
    repeat (12) step();
    check("fill_pops", 32'(pops - n0), 32'd0);
    check("fill_occupancy", 32'(ep_acc - ep_pop), 32'(FQ_DEPTH));
    check("fill_req_blocked", 32'(imem_req_valid), 32'd0);
    check("fill_head_valid", 32'(instr_valid), 32'd1);
    check("fill_mem_idle", 32'(mq.size()), 32'd0);
    instr_ready = 1'b1;
    repeat (8) step();

    // Redirect with two requests in flight.
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 20 && !(mq.size() == 2 && !imem_rsp_valid); i++) step();
    check("redir_two_outst", 32'(mq.size()), 32'd2);
    redirect_en   = 1'b1;
    redirect_addr = 32'h100;
    step();
    redirect_en = 1'b0;
    check("redir_taken_pulse", 32'(redirect_taken), 32'd1);
    nf = 0;
    for (int i = 0; i < 10 && old_pending() > 0; i++) begin
      step();
      nf++;
    end
    check("flush_cycles", 32'(nf), 32'd2);
    n0 = pops;
    for (int i = 0; i < 20 && pops == n0; i++) step();
    check("redir_pop_seen", 32'(pops > n0), 32'd1);
    check("redir_first_pc", last_pop_pc, 32'h100);

    // Halt mid-stream: queue drains, no requests, then sequential resume.
    lat_min = 1; lat_max = 1;
    instr_ready = 1'b0;
    repeat (3) step();
    halt        = 1'b1;
    instr_ready = 1'b1;
    repeat (10) step();
    check("halt_drained", 32'(instr_valid), 32'd0);
    check("halt_mem_idle", 32'(mq.size()), 32'd0);
    tgt  = exp_req_pc;
    halt = 1'b0;
    n0   = accs;
    step();
    check("halt_resume_req", 32'(accs - n0), 32'd1);
    check("halt_resume_addr", last_acc_addr, tgt);

    // Redirect coinciding with a returning response and a decode pop.
    for (int i = 0; i < 20 && !(instr_valid && imem_rsp_valid); i++) step();
    check("rrp_setup", 32'(instr_valid && imem_rsp_valid), 32'd1);
    redirect_en   = 1'b1;
    redirect_addr = 32'h200;
    step();
    redirect_en = 1'b0;
    check("rrp_queue_empty", 32'(instr_valid), 32'd0);
    check("rrp_taken", 32'(redirect_taken), 32'd1);
    repeat (6) step();

    // Misaligned redirect target.
    redirect_en   = 1'b1;
    redirect_addr = 32'h102;
    step();
    redirect_en = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
    check("misalign_fault_set", 32'(misalign_fault), 32'd1);
    n0 = accs;
    repeat (8) step();
    check("misalign_stop", 32'(accs - n0), 32'd0);
    check("misalign_sticky", 32'(misalign_fault), 32'd1);
`else
    check("misalign_fault_off", 32'(misalign_fault), 32'd0);
    n0 = accs;
    for (int i = 0; i < 10 && accs == n0; i++) step();
    check("misalign_req_seen", 32'(accs > n0), 32'd1);
    check("misalign_aligned_addr", last_acc_addr, 32'h100);
    repeat (3) step();
`endif

    // Reset while traffic is live.
    do_reset();

    // Random traffic, including redirects near the top of the address space.
    lat_min = 1; lat_max = 4;
    n0 = pops;
    for (int i = 0; i < 1500; i++) begin
      halt           = ($urandom_range(99, 0) < 8);
      imem_req_ready = ($urandom_range(99, 0) < 75);
      instr_ready    = ($urandom_range(99, 0) < 70);
      redirect_en    = ($urandom_range(99, 0) < 3);
      if (redirect_en) begin
        case ($urandom_range(2, 0))
          0:       tgt = 32'hFFFF_FFF0;
          1:       tgt = $urandom_range(255, 0) << 2;
          default: tgt = $urandom;
        endcase
`ifdef FETCH_MISALIGN_CHK_EN
        tgt[1:0] = 2'b00;
`endif
        redirect_addr = tgt;
      end
      step();
    end
    redirect_en = 1'b0;
    halt        = 1'b0;
    check("random_progress", 32'(pops - n0 > 200), 32'd1);
    check("random_no_fault", 32'(misalign_fault), 32'd0);

    // Second mid-traffic reset, then restart from the reset vector.
    do_reset();
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    lat_min = 1; lat_max = 1;
    n0 = pops;
    repeat (6) step();
    check("restart_pops", 32'(pops - n0), 32'd4);
    check("restart_last_pc", last_pop_pc, RV + 32'd12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
